// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the variable-latency instruction
// memory handshake and holds the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PCWrite,
  input  logic                 IFIDWrite,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_target,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_inputReady,
  output logic [WORD_SIZE-1:0] IFID_instr,
  output logic [WORD_SIZE-1:0] IFID_pc,
  output logic [WORD_SIZE-1:0] IFID_next_pc,
  output logic                 IFID_valid
);

  // state    | meaning
  // FETCH    | read request outstanding at pc
  // BUFFERED | instruction captured during a stall, waiting for hold to drop
  // DRAIN    | redirect arrived mid-request; discard stale response, then fetch target
  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    BUFFERED = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  state_t               state;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pc_inc;
  logic [WORD_SIZE-1:0] target;
  logic [WORD_SIZE-1:0] buf_instr;
  logic [WORD_SIZE-1:0] buf_pc;
  logic                 hold;

  assign hold      = PCWrite | IFIDWrite;
  assign pc_inc    = pc + ONE;
  assign i_address = pc;
  // The request line is gated by reset so an in-flight request is dropped at once.
  assign i_readM   = ~reset & (state != BUFFERED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      target       <= '0;
      buf_instr    <= NOP_INSTR;
      buf_pc       <= '0;
      IFID_instr   <= NOP_INSTR;
      IFID_pc      <= '0;
      IFID_next_pc <= '0;
      IFID_valid   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            IFID_valid <= 1'b0;
            IFID_instr <= NOP_INSTR;
            if (i_inputReady) begin
              pc <= redirect_target;
            end else begin
              target <= redirect_target;
              state  <= DRAIN;
            end
          end else if (i_inputReady) begin
            if (hold) begin
              buf_instr <= i_data;
              buf_pc    <= pc;
              state     <= BUFFERED;
            end else begin
              IFID_instr   <= i_data;
              IFID_pc      <= pc;
              IFID_next_pc <= pc_inc;
              IFID_valid   <= 1'b1;
              pc           <= pc_inc;
            end
          end else if (!hold) begin
            IFID_valid <= 1'b0;
            IFID_instr <= NOP_INSTR;
          end
        end

        BUFFERED: begin
          if (redirect) begin
            pc         <= redirect_target;
            IFID_valid <= 1'b0;
            IFID_instr <= NOP_INSTR;
            state      <= FETCH;
          end else if (!hold) begin
            // pc still equals buf_pc here, so pc_inc is the buffered entry's next pc
            IFID_instr   <= buf_instr;
            IFID_pc      <= buf_pc;
            IFID_next_pc <= pc_inc;
            IFID_valid   <= 1'b1;
            pc           <= pc_inc;
            state        <= FETCH;
          end
        end

        DRAIN: begin
          if (redirect) begin
            IFID_valid <= 1'b0;
            IFID_instr <= NOP_INSTR;
            if (i_inputReady) begin
              pc    <= redirect_target;
              state <= FETCH;
            end else begin
              target <= redirect_target;
            end
          end else begin
            if (!hold) begin
              IFID_valid <= 1'b0;
              IFID_instr <= NOP_INSTR;
            end
            if (i_inputReady) begin
              pc    <= target;
              state <= FETCH;
            end
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, back-to-back fetch, latency, stalls,
// redirects (including redirect during a stall) and PC wrap-around.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, hold, redir, rdy;
  logic [15:0] tgt;
  logic        i_readM;
  logic [15:0] i_address, i_data;
  logic [15:0] IFID_instr, IFID_pc, IFID_next_pc;
  logic        IFID_valid;

  logic        w_reset;
  logic        w_readM;
  logic [15:0] w_address, w_data;
  logic [15:0] w_instr, w_pc, w_next_pc;
  logic        w_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory contents: mem[a] = (a+1)*0x1111, so mem[0..3] = 1111..4444.
  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [15:0] s;
    if (a == 16'hFFFF) return 16'hFACE;
    s = a + 16'd1;
    return s * 16'h1111;
  endfunction

  assign i_data = rdy ? memf(i_address) : 16'hDEAD;
  assign w_data = memf(w_address);

  fetch_stage #(.WORD_SIZE(16), .RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk(clk), .reset(reset), .PCWrite(hold), .IFIDWrite(hold),
    .redirect(redir), .redirect_target(tgt),
    .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_inputReady(rdy),
    .IFID_instr(IFID_instr), .IFID_pc(IFID_pc), .IFID_next_pc(IFID_next_pc),
    .IFID_valid(IFID_valid)
  );

  fetch_stage #(.WORD_SIZE(16), .RESET_PC(16'hFFFF), .NOP_INSTR(16'h0000)) u_wrap (
    .clk(clk), .reset(w_reset), .PCWrite(1'b0), .IFIDWrite(1'b0),
    .redirect(1'b0), .redirect_target(16'h0000),
    .i_readM(w_readM), .i_address(w_address), .i_data(w_data), .i_inputReady(1'b1),
    .IFID_instr(w_instr), .IFID_pc(w_pc), .IFID_next_pc(w_next_pc),
    .IFID_valid(w_valid)
  );

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [15:0] ins,
                          input logic [15:0] p, input logic [15:0] np);
    chk1 ({tag, ".valid"}, IFID_valid, v);
    chk16({tag, ".instr"}, IFID_instr, ins);
    chk16({tag, ".pc"},    IFID_pc,    p);
    chk16({tag, ".next"},  IFID_next_pc, np);
  endtask

  initial begin
    reset = 1'b1; w_reset = 1'b1; hold = 1'b0; redir = 1'b0; tgt = 16'h0; rdy = 1'b1;
    tick(); tick();
    chk_ifid("rst", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    chk1 ("rst.readM", i_readM, 1'b0);
    chk16("rst.addr",  i_address, 16'h0000);

    // Back-to-back fetch with memory ready every cycle
    reset = 1'b0;
    #1;
    chk1 ("b2b.readM", i_readM, 1'b1);
    chk16("b2b.addr0", i_address, 16'h0000);
    tick(); chk_ifid("b2b0", 1'b1, 16'h1111, 16'h0000, 16'h0001);
    tick(); chk_ifid("b2b1", 1'b1, 16'h2222, 16'h0001, 16'h0002);
    tick(); chk_ifid("b2b2", 1'b1, 16'h3333, 16'h0002, 16'h0003);
    tick(); chk_ifid("b2b3", 1'b1, 16'h4444, 16'h0003, 16'h0004);

    // Asynchronous reset mid-cycle
    #2; reset = 1'b1; #1;
    chk_ifid("arst", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    chk1 ("arst.readM", i_readM, 1'b0);
    chk16("arst.addr",  i_address, 16'h0000);
    tick();
    reset = 1'b0; rdy = 1'b0;

    // Latency 3: ready every third cycle
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1 ("lat.v0", IFID_valid, 1'b0);
      chk16("lat.a0", i_address, 16'(k));
      tick();
      chk1 ("lat.v1", IFID_valid, 1'b0);
      chk16("lat.a1", i_address, 16'(k));
      rdy = 1'b1;
      tick();
      chk_ifid("lat.del", 1'b1, memf(16'(k)), 16'(k), 16'(k + 1));
      rdy = 1'b0;
    end

    // Stall while mem[5] returns
    rdy = 1'b1;
    tick(); chk_ifid("st.i3", 1'b1, 16'h4444, 16'h0003, 16'h0004);
    tick(); chk_ifid("st.i4", 1'b1, 16'h5555, 16'h0004, 16'h0005);
    hold = 1'b1;
    tick(); chk_ifid("st.h0", 1'b1, 16'h5555, 16'h0004, 16'h0005);
    chk1("st.h0.readM", i_readM, 1'b0);
    tick(); chk_ifid("st.h1", 1'b1, 16'h5555, 16'h0004, 16'h0005);
    chk1("st.h1.readM", i_readM, 1'b0);
    hold = 1'b0;
    tick(); chk_ifid("st.i5", 1'b1, 16'h6666, 16'h0005, 16'h0006);
    chk1 ("st.readM", i_readM, 1'b1);
    chk16("st.addr",  i_address, 16'h0006);
    tick(); chk_ifid("st.i6", 1'b1, 16'h7777, 16'h0006, 16'h0007);

    // Redirect while the request at pc=7 is outstanding
    rdy = 1'b0;
    tick(); chk1("rd.bub", IFID_valid, 1'b0);
    chk16("rd.addr7", i_address, 16'h0007);
    redir = 1'b1; tgt = 16'h0040;
    tick();
    redir = 1'b0;
    chk1 ("rd.v0", IFID_valid, 1'b0);
    chk1 ("rd.readM", i_readM, 1'b1);
    chk16("rd.drain.addr", i_address, 16'h0007);
    tick();
    chk16("rd.wait.addr", i_address, 16'h0007);
    rdy = 1'b1;
    tick();
    chk1 ("rd.stale", IFID_valid, 1'b0);
    chk16("rd.tgt.addr", i_address, 16'h0040);
    rdy = 1'b0;
    tick(); chk1("rd.v1", IFID_valid, 1'b0);
    rdy = 1'b1;
    tick(); chk_ifid("rd.i40", 1'b1, memf(16'h0040), 16'h0040, 16'h0041);

    // Redirect together with hold while data sits in the buffer
    hold = 1'b1;
    tick(); chk_ifid("rh.buf", 1'b1, memf(16'h0040), 16'h0040, 16'h0041);
    chk1("rh.readM", i_readM, 1'b0);
    redir = 1'b1; tgt = 16'h0080; rdy = 1'b0;
    tick();
    redir = 1'b0; hold = 1'b0; rdy = 1'b1;
    chk1 ("rh.v", IFID_valid, 1'b0);
    chk16("rh.nop", IFID_instr, 16'h0000);
    chk16("rh.addr", i_address, 16'h0080);
    tick(); chk_ifid("rh.i80", 1'b1, memf(16'h0080), 16'h0080, 16'h0081);

    // Redirect in FETCH with the response arriving the same cycle
    redir = 1'b1; tgt = 16'h0010;
    tick();
    redir = 1'b0;
    chk1 ("rr.v", IFID_valid, 1'b0);
    chk16("rr.addr", i_address, 16'h0010);
    tick(); chk_ifid("rr.i10", 1'b1, memf(16'h0010), 16'h0010, 16'h0011);

    // PC wrap-around from RESET_PC=FFFF
    w_reset = 1'b0;
    #1;
    chk16("wr.addr0", w_address, 16'hFFFF);
    tick();
    chk1 ("wr.v",    w_valid,   1'b1);
    chk16("wr.instr", w_instr,  16'hFACE);
    chk16("wr.pc",   w_pc,      16'hFFFF);
    chk16("wr.next", w_next_pc, 16'h0000);
    chk16("wr.addr1", w_address, 16'h0000);
    tick();
    chk16("wr.pc0",  w_pc,      16'h0000);
    chk16("wr.ins0", w_instr,   16'h1111);
    chk16("wr.nxt1", w_next_pc, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
